// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write initiator and its peripheral:
// frame geometry, register map and controller state encoding.
package spi_pkg;

    localparam int ADDRESS_SIZE = 7;
    localparam int DATA_SIZE    = 8;
    localparam int FRAME_SIZE   = 1 + ADDRESS_SIZE + DATA_SIZE;

    localparam logic [ADDRESS_SIZE-1:0] REG_EN_OUT_7_0  = 7'd0;
    localparam logic [ADDRESS_SIZE-1:0] REG_EN_OUT_15_8 = 7'd1;
    localparam logic [ADDRESS_SIZE-1:0] REG_EN_PWM_7_0  = 7'd2;
    localparam logic [ADDRESS_SIZE-1:0] REG_EN_PWM_15_8 = 7'd3;
    localparam logic [ADDRESS_SIZE-1:0] REG_PWM_DUTY    = 7'd4;
    localparam logic [ADDRESS_SIZE-1:0] REG_MAX         = 7'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Loading N-1 on entry to a phase makes that phase last N cycles.
module spi_phase_timer #(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_value,
    output logic          tc
);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises one {rw, addr, data} frame per accepted
// command, MSB first, with nCS setup/hold and an inter-frame idle gap.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | nCS high, cmd_ready high, waiting for cmd_valid
// SETUP    | nCS low, SCLK low, COPI already showing the frame MSB
// SHIFT_LO | SCLK low half-period, COPI stable on the current bit
// SHIFT_HI | SCLK high half-period, receiver samples on the rise
// HOLD     | SCLK low after the last fall, nCS still low, COPI = bit 0
// GAP      | nCS high, done pulses on the first cycle, busy still high
module spi_controller
    import spi_pkg::*;
#(
    parameter int W        = DATA_SIZE,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int IDLE_GAP = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rw,
    input  logic [ADDRESS_SIZE-1:0] cmd_addr,
    input  logic [W-1:0]            cmd_data,
    output logic                    SCLK,
    output logic                    nCS,
    output logic                    COPI,
    output logic                    busy,
    output logic                    done
);

    localparam int FRAME = 1 + ADDRESS_SIZE + W;
    localparam int TW    = $clog2(max_of4(CLK_DIV, CS_SETUP, CS_HOLD, IDLE_GAP)) + 1;

    spi_state_t       state, state_next;
    logic [FRAME-1:0] shreg, shreg_next;
    logic [4:0]       bit_cnt, bit_cnt_next;
    logic             sclk_next, ncs_next, copi_next, busy_next, done_next, ready_next;
    logic             timer_load, timer_tc;
    logic [TW-1:0]    timer_value;

    spi_phase_timer #(.TW(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (timer_tc)
    );

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        sclk_next    = SCLK;
        ncs_next     = nCS;
        copi_next    = COPI;
        busy_next    = busy;
        done_next    = 1'b0;
        ready_next   = cmd_ready;
        timer_load   = 1'b0;
        timer_value  = '0;

        case (state)
            ST_IDLE: begin
                sclk_next  = 1'b0;
                ncs_next   = 1'b1;
                copi_next  = 1'b0;
                busy_next  = 1'b0;
                ready_next = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    state_next   = ST_SETUP;
                    shreg_next   = {cmd_rw, cmd_addr, cmd_data};
                    bit_cnt_next = 5'(FRAME - 1);
                    ncs_next     = 1'b0;
                    copi_next    = cmd_rw;
                    busy_next    = 1'b1;
                    ready_next   = 1'b0;
                    timer_load   = 1'b1;
                    timer_value  = TW'(CS_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (timer_tc) begin
                    state_next  = ST_SHIFT_LO;
                    timer_load  = 1'b1;
                    timer_value = TW'(CLK_DIV - 1);
                end
            end
            ST_SHIFT_LO: begin
                if (timer_tc) begin
                    state_next  = ST_SHIFT_HI;
                    sclk_next   = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = TW'(CLK_DIV - 1);
                end
            end
            ST_SHIFT_HI: begin
                if (timer_tc) begin
                    sclk_next  = 1'b0;
                    timer_load = 1'b1;
                    if (bit_cnt == '0) begin
                        state_next  = ST_HOLD;
                        timer_value = TW'(CS_HOLD - 1);
                    end else begin
                        // COPI advances on the SCLK fall so it is stable a full low phase
                        state_next   = ST_SHIFT_LO;
                        bit_cnt_next = bit_cnt - 5'd1;
                        shreg_next   = shreg << 1;
                        copi_next    = shreg[FRAME-2];
                        timer_value  = TW'(CLK_DIV - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (timer_tc) begin
                    state_next  = ST_GAP;
                    ncs_next    = 1'b1;
                    copi_next   = 1'b0;
                    done_next   = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = TW'(IDLE_GAP - 1);
                end
            end
            ST_GAP: begin
                if (timer_tc) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    ready_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            SCLK      <= 1'b0;
            nCS       <= 1'b1;
            COPI      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            bit_cnt   <= bit_cnt_next;
            SCLK      <= sclk_next;
            nCS       <= ncs_next;
            COPI      <= copi_next;
            busy      <= busy_next;
            done      <= done_next;
            cmd_ready <= ready_next;
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a behavioural SPI register peripheral plus frame
// monitor, table-driven frames and hand-written multi-cycle sequences.
module tb_spi_controller;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, SCLK, nCS, COPI, busy, done;

    spi_controller dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .SCLK      (SCLK),
        .nCS       (nCS),
        .COPI      (COPI),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral model and waveform monitor, sampled on the falling edge.
    logic        prev_sclk = 1'b0;
    logic        prev_ncs  = 1'b1;
    logic [15:0] word = '0;
    logic [7:0]  regs [0:4] = '{default: 8'h00};
    int edges = 0, low_cnt = 0, high_run = 0, last_gap = 0;
    int done_cnt = 0, done_cyc = 0, frames = 0, viol = 0;

    always @(negedge clk) begin
        if (prev_ncs && !nCS) begin
            edges    = 0;
            word     = '0;
            low_cnt  = 0;
            last_gap = high_run;
            frames++;
        end
        if (!nCS) begin
            low_cnt++;
            high_run = 0;
        end else begin
            high_run++;
        end
        if (SCLK && !prev_sclk) begin
            edges++;
            word = {word[14:0], COPI};
        end
        if (!rst && SCLK && nCS) viol++;
        if (!rst && (SCLK !== prev_sclk) && (nCS !== prev_ncs)) viol++;
        if (!prev_ncs && nCS && edges == 16 && word[15] && word[14:8] <= REG_MAX)
            regs[int'(word[14:8])] = word[7:0];
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_sclk = SCLK;
        prev_ncs  = nCS;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Presents a command and returns the cycle index in which it was accepted;
    // cmd_valid is left high when hold is set.
    task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d,
                        input bit hold, output int acc);
        bit ok;
        ok = 1'b0;
        acc = 0;
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_data  = d;
        for (int k = 0; k < 400; k++) begin
            if (cmd_ready) begin
                acc = cyc;
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("accept_timeout", 0, 1);
        tick();
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 400 && done_cnt < target; k++) tick();
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] exp_word;
        int          reg_idx;
        logic [7:0]  reg_val;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, d0, f0;

        vecs[0] = '{1'b1, 7'h00, 8'hA5, 16'h80A5, 0, 8'hA5};
        vecs[1] = '{1'b1, 7'h04, 8'h80, 16'h8480, 4, 8'h80};
        vecs[2] = '{1'b0, 7'h01, 8'hFF, 16'h01FF, 1, 8'h00};
        vecs[3] = '{1'b1, 7'h7F, 8'h55, 16'hFF55, 0, 8'hA5};

        rst = 1'b1;
        repeat (3) tick();
        check("rst_sclk",  int'(SCLK), 0);
        check("rst_ncs",   int'(nCS), 1);
        check("rst_copi",  int'(COPI), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_ready", int'(cmd_ready), 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", int'(cmd_ready), 1);

        for (int i = 0; i < 4; i++) begin
            d0 = done_cnt;
            send(vecs[i].rw, vecs[i].addr, vecs[i].data, 1'b0, acc);
            check("busy_after_accept", int'(busy), 1);
            check("ready_after_accept", int'(cmd_ready), 0);
            check("ncs_after_accept", int'(nCS), 0);
            check("copi_msb", int'(COPI), int'(vecs[i].exp_word[15]));
            wait_done(d0 + 1);
            check("frame_word", int'(word), int'(vecs[i].exp_word));
            check("sclk_rises", edges, 16);
            check("ncs_low_cycles", low_cnt, 136);
            check("done_latency", done_cyc - acc, 137);
            repeat (6) tick();
            check("done_once", done_cnt, d0 + 1);
            check("reg_value", int'(regs[vecs[i].reg_idx]), int'(vecs[i].reg_val));
        end
        check("reg1_zero", int'(regs[1]), 0);
        check("reg2_zero", int'(regs[2]), 0);
        check("reg3_zero", int'(regs[3]), 0);

        // back-to-back with cmd_valid held high
        d0 = done_cnt;
        send(1'b1, REG_EN_PWM_7_0, 8'h0F, 1'b1, acc);
        cmd_addr = REG_EN_PWM_15_8;
        cmd_data = 8'hF0;
        send(1'b1, REG_EN_PWM_15_8, 8'hF0, 1'b0, acc2);
        check("b2b_spacing", acc2 - acc, 141);
        check("b2b_ncs_gap_ge4", int'(last_gap >= 4), 1);
        wait_done(d0 + 2);
        repeat (3) tick();
        check("reg_pwm_7_0", int'(regs[2]), 8'h0F);
        check("reg_pwm_15_8", int'(regs[3]), 8'hF0);

        // reset after the 5th SCLK rise
        d0 = done_cnt;
        send(1'b1, REG_EN_OUT_15_8, 8'h33, 1'b0, acc);
        for (int k = 0; k < 200 && edges < 5; k++) tick();
        check("rst_mid_reached_5", edges, 5);
        rst = 1'b1;
        tick();
        check("mid_rst_ncs",  int'(nCS), 1);
        check("mid_rst_sclk", int'(SCLK), 0);
        check("mid_rst_copi", int'(COPI), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();
        check("mid_rst_ready", int'(cmd_ready), 1);
        repeat (5) tick();
        check("mid_rst_no_done", done_cnt, d0);
        check("mid_rst_no_commit", int'(regs[1]), 0);
        send(1'b1, REG_EN_OUT_15_8, 8'h33, 1'b0, acc);
        wait_done(d0 + 1);
        repeat (3) tick();
        check("retry_commit", int'(regs[1]), 8'h33);

        // inputs change after accept, extra request while busy
        d0 = done_cnt;
        send(1'b1, REG_EN_OUT_7_0, 8'h11, 1'b0, acc);
        cmd_data = 8'hEE;
        f0 = frames;
        repeat (10) tick();
        cmd_valid = 1'b1;
        cmd_addr  = REG_EN_PWM_7_0;
        cmd_data  = 8'h99;
        check("busy_ready_low", int'(cmd_ready), 0);
        tick();
        cmd_valid = 1'b0;
        wait_done(d0 + 1);
        check("stable_word", int'(word), 16'h8011);
        repeat (10) tick();
        check("no_extra_frame", frames, f0);
        check("stable_reg0", int'(regs[0]), 8'h11);
        check("untouched_reg2", int'(regs[2]), 8'h0F);
        check("protocol_violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
